// File: rtl/mux_scan_pkg.sv
// rtl/mux_scan_pkg.sv - shared types and constants for the mux scan sequencer
package mux_scan_pkg;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/mux_scan_dwell_cnt.sv
// rtl/mux_scan_dwell_cnt.sv - loadable dwell down-counter with zero flag
module mux_scan_dwell_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    // load wins over decrement; the count parks at zero until reloaded
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mux_scan_sequencer.sv
// rtl/mux_scan_sequencer.sv - steps a 4:1 mux select, samples Y per channel, emits 4-bit frames (MUX_SCAN_CONT_EN: continuous rescans)
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 2,
    parameter int CNT_W = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       Y,
    output logic       S0,
    output logic       S1,
    output logic       busy,
    output logic [3:0] frame_data,
    output logic       frame_valid,
    input  logic       frame_ready
);

    localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(DWELL - 1);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);

    state_t              state;
    logic [CH_W-1:0]     ch;
    logic [NUM_CH-2:0]   shadow;
    logic                cnt_load;
    logic                cnt_dec;
    logic                cnt_zero;
    logic                handshake;
    logic                last_ch;

    assign handshake = frame_valid & frame_ready;
    assign last_ch   = (ch == LAST_CH);

    // reload the dwell count whenever a channel (or a whole scan) begins
    always_comb begin
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        if (state == IDLE && start) begin
            cnt_load = 1'b1;
        end
        if (state == SETTLE) begin
            if (cnt_zero) begin
                cnt_load = !last_ch;
            end else begin
                cnt_dec = 1'b1;
            end
        end
`ifdef MUX_SCAN_CONT_EN
        if (state == DONE && handshake) begin
            cnt_load = 1'b1;
        end
`endif
    end

    mux_scan_dwell_cnt #(
        .CNT_W(CNT_W)
    ) u_dwell_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (RELOAD),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // scan FSM: channel stepping, Y capture, frame hand-off; select lines are registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ch          <= '0;
            shadow      <= '0;
            S0          <= 1'b0;
            S1          <= 1'b0;
            busy        <= 1'b0;
            frame_data  <= 4'b0000;
            frame_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    {S1, S0} <= 2'b00;
                    if (start) begin
                        state  <= SETTLE;
                        ch     <= '0;
                        shadow <= '0;
                        busy   <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (cnt_zero) begin
                        if (!last_ch) begin
                            shadow[ch] <= Y;
                            ch         <= ch + 2'd1;
                            {S1, S0}   <= ch + 2'd1;
                        end else begin
                            // the final channel's Y goes straight into the frame
                            frame_data  <= {Y, shadow};
                            frame_valid <= 1'b1;
                            {S1, S0}    <= 2'b00;
                            state       <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (handshake) begin
                        frame_valid <= 1'b0;
`ifdef MUX_SCAN_CONT_EN
                        state  <= SETTLE;
                        ch     <= '0;
                        shadow <= '0;
`else
                        state <= IDLE;
                        busy  <= 1'b0;
`endif
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    {S1, S0} <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb/tb_mux_scan_sequencer.sv - self-checking bench for mux_scan_sequencer (DWELL=2 and DWELL=1 instances)
module tb_mux_scan_sequencer;

    logic       clk;
    logic       rst;
    logic [1:0] start_v;
    logic [1:0] ready_v;
    logic [1:0] y_v;
    logic [1:0] s0_v;
    logic [1:0] s1_v;
    logic [1:0] busy_v;
    logic [1:0] valid_v;
    logic [3:0] fd   [2];
    logic [3:0] abcd [2];

    int n_cmp = 0;
    int n_err = 0;

    // model state: phase 0 idle, 1 scanning, 2 holding a frame; t = cycles into the scan
    int         ph [2];
    int         t  [2];
    logic [3:0] acc    [2];
    logic [3:0] mframe [2];
    logic       mvalid [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural 4:1 mux in front of each sequencer: A=bit0 .. D=bit3
    assign y_v[0] = abcd[0][{s1_v[0], s0_v[0]}];
    assign y_v[1] = abcd[1][{s1_v[1], s0_v[1]}];

    mux_scan_sequencer #(.DWELL(2), .CNT_W(4)) u_dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .Y(y_v[0]),
        .S0(s0_v[0]), .S1(s1_v[0]), .busy(busy_v[0]),
        .frame_data(fd[0]), .frame_valid(valid_v[0]), .frame_ready(ready_v[0])
    );

    mux_scan_sequencer #(.DWELL(1), .CNT_W(4)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .Y(y_v[1]),
        .S0(s0_v[1]), .S1(s1_v[1]), .busy(busy_v[1]),
        .frame_data(fd[1]), .frame_valid(valid_v[1]), .frame_ready(ready_v[1])
    );

    function automatic int dw(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model: advances once per rising edge, resets on rst
    initial begin
        for (int i = 0; i < 2; i++) begin
            ph[i] = 0; t[i] = 0; acc[i] = '0; mframe[i] = '0; mvalid[i] = 1'b0;
        end
        forever begin
            @(posedge clk or posedge rst);
            for (int i = 0; i < 2; i++) begin
                if (rst) begin
                    ph[i] = 0; t[i] = 0; acc[i] = '0; mframe[i] = '0; mvalid[i] = 1'b0;
                end else if (ph[i] == 0) begin
                    if (start_v[i]) begin
                        ph[i] = 1; t[i] = 0; acc[i] = '0;
                    end
                end else if (ph[i] == 1) begin
                    if ((t[i] % dw(i)) == dw(i) - 1)
                        acc[i][t[i] / dw(i)] = abcd[i][t[i] / dw(i)];
                    t[i] = t[i] + 1;
                    if (t[i] == 4 * dw(i)) begin
                        mframe[i] = acc[i];
                        mvalid[i] = 1'b1;
                        ph[i]     = 2;
                    end
                end else begin
                    if (ready_v[i]) begin
                        mvalid[i] = 1'b0;
                        t[i]      = 0;
                        acc[i]    = '0;
`ifdef MUX_SCAN_CONT_EN
                        ph[i] = 1;
`else
                        ph[i] = 0;
`endif
                    end
                end
            end
        end
    end

    // every-cycle comparison of both DUTs against the model
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int i = 0; i < 2; i++) begin
                    check($sformatf("sel%0d", i), {s1_v[i], s0_v[i]},
                          (ph[i] == 1) ? 32'(t[i] / dw(i)) : 32'd0);
                    check($sformatf("busy%0d", i), busy_v[i], ph[i] != 0);
                    check($sformatf("valid%0d", i), valid_v[i], mvalid[i]);
                    check($sformatf("data%0d", i), fd[i], mframe[i]);
                end
            end
        end
    end

    task automatic start_scan(input int i);
        @(negedge clk);
        start_v[i] = 1'b1;
        @(negedge clk);
        start_v[i] = 1'b0;
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    logic [15:0] seq;
    int          late_valid;

    initial begin
        rst = 1'b1; start_v = '0; ready_v = '0;
        abcd[0] = '0; abcd[1] = '0;
        seq = 16'b11_11_10_10_01_01_00_00;
        repeat (3) @(negedge clk);
        check("rst_sel", {s1_v[0], s0_v[0]}, 2'b00);
        check("rst_busy", busy_v[0], 1'b0);
        check("rst_valid", valid_v[0], 1'b0);
        check("rst_data", fd[0], 4'b0000);
        @(posedge clk);
        #2 rst = 1'b0;

        // single-hot A, ready held high: select walk and 8-cycle latency
        abcd[0] = 4'b0001; ready_v[0] = 1'b1;
        start_scan(0);
        for (int j = 0; j < 8; j++) begin
            check($sformatf("t1_seq%0d", j), {s1_v[0], s0_v[0]}, seq[2*j +: 2]);
            if (j == 7) check("t1_early_valid", valid_v[0], 1'b0);
            @(negedge clk);
        end
        check("t1_valid", valid_v[0], 1'b1);
        check("t1_data", fd[0], 4'b0001);
        @(negedge clk);
        check("t1_hs_drop", valid_v[0], 1'b0);
        pulse_rst();

        // back-pressure: frame held stable while ready is low
        abcd[0] = 4'b0110; ready_v[0] = 1'b0;
        start_scan(0);
        repeat (8) @(negedge clk);
        check("t2_valid", valid_v[0], 1'b1);
        check("t2_data", fd[0], 4'b0110);
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            check("t2_hold_valid", valid_v[0], 1'b1);
            check("t2_hold_data", fd[0], 4'b0110);
        end
        ready_v[0] = 1'b1;
        @(negedge clk);
        check("t2_hs_drop", valid_v[0], 1'b0);
`ifndef MUX_SCAN_CONT_EN
        check("t2_idle_busy", busy_v[0], 1'b0);
`endif
        ready_v[0] = 1'b0;
        pulse_rst();

        // second start mid-scan must be ignored
        abcd[0] = 4'b0100; ready_v[0] = 1'b1;
        start_scan(0);
        repeat (3) @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (4) @(negedge clk);
        check("t3_valid", valid_v[0], 1'b1);
        check("t3_data", fd[0], 4'b0100);
        late_valid = 0;
        repeat (20) begin
            @(negedge clk);
            if (valid_v[0]) late_valid++;
        end
`ifndef MUX_SCAN_CONT_EN
        check("t3_one_frame", late_valid, 0);
        check("t3_busy", busy_v[0], 1'b0);
`endif
        pulse_rst();

        // reset while channel 2 is selected, then a clean D-only frame
        abcd[0] = 4'b0111; ready_v[0] = 1'b1;
        start_scan(0);
        repeat (4) @(negedge clk);
        check("t4_on_ch2", {s1_v[0], s0_v[0]}, 2'b10);
        #1 rst = 1'b1;
        #1;
        check("t4_rst_sel", {s1_v[0], s0_v[0]}, 2'b00);
        check("t4_rst_busy", busy_v[0], 1'b0);
        check("t4_rst_valid", valid_v[0], 1'b0);
        @(posedge clk);
        #2 rst = 1'b0;
        abcd[0] = 4'b1000;
        start_scan(0);
        repeat (8) @(negedge clk);
        check("t4_valid", valid_v[0], 1'b1);
        check("t4_data", fd[0], 4'b1000);
        pulse_rst();

        // DWELL=1 instance: four-cycle frame
        abcd[1] = 4'b1111; ready_v[1] = 1'b1;
        start_scan(1);
        repeat (3) @(negedge clk);
        check("t5_early_valid", valid_v[1], 1'b0);
        @(negedge clk);
        check("t5_valid", valid_v[1], 1'b1);
        check("t5_data", fd[1], 4'b1111);
`ifdef MUX_SCAN_CONT_EN
        repeat (5) @(negedge clk);
        check("t5_cont_valid", valid_v[1], 1'b1);
        check("t5_cont_data", fd[1], 4'b1111);
`endif
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
